systolic_ctrl: RTL and testbench
================================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, both listed first below.
REQ-002 Parameter N, default 4, SHALL set the array dimension (N x N PEs), N >= 1.
REQ-003 Parameter KW, default 8, SHALL set the width of k_len_i.
REQ-004 clk_i  input  1  SHALL be the only clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 start_i  input  1  SHALL be the job request; it is sampled only in IDLE.
REQ-007 load_w_i  input  1  SHALL select the weight load phase (1) or reuse of the resident weights (0); it is sampled with start_i.
REQ-008 k_len_i  input  KW  SHALL give K, the number of activation vectors; it is sampled with start_i.
REQ-009 busy_o  output  1  SHALL be high in every state except IDLE.
REQ-010 done_o  output  1  SHALL be a single-cycle job-complete pulse.
REQ-011 pe_mux_o  output  input_mux_t  SHALL be the mode broadcast to every PE mux_i.
REQ-012 add_zero_o  output  N  SHALL drive add_zero_i per PE row r (all columns of the row).
REQ-013 w_req_o  output  1  SHALL request one weight row on the top inputs of row 0 in the same cycle.
REQ-014 w_row_o  output  clog2(N) (min 1)  SHALL give the index of the requested weight row.
REQ-015 a_valid_o  output  N  SHALL enable the activation feed at the left input of row r in the same cycle (skewed).
REQ-016 out_valid_o  output  N  SHALL mark bottom_o of row N-1, column c, as a valid result this cycle.

Function
REQ-017 The block SHALL implement the states IDLE, LOAD_SHIFT, LOAD_LATCH, COMPUTE and DONE.
REQ-018 In IDLE with start_i=1, the block SHALL capture load_w_i and K, then go to LOAD_SHIFT if load_w_i=1 and N>1, to LOAD_LATCH if load_w_i=1 and N=1, and otherwise to COMPUTE.
REQ-019 LOAD_SHIFT SHALL last exactly N-1 cycles: pe_mux_o=PASSTHROUGH, w_req_o=1, w_row_o=N-1-i on shift cycle i.
REQ-020 LOAD_LATCH SHALL last exactly 1 cycle: pe_mux_o=LOAD, w_req_o=1, w_row_o=0; the next state is COMPUTE.
REQ-021 COMPUTE SHALL run a counter t from 0 to K+2N-2 inclusive (K+2N-1 cycles) with pe_mux_o=PROCESS.
REQ-022 In COMPUTE, a_valid_o[r] SHALL be 1 iff r <= t <= r+K-1.
REQ-023 In COMPUTE, out_valid_o[c] SHALL be 1 iff N+c <= t <= N+c+K-1.
REQ-024 In COMPUTE, add_zero_o[0] SHALL be 1 and add_zero_o[r>0] SHALL be 0.
REQ-025 If K=0, COMPUTE SHALL be skipped (no a_valid_o/out_valid_o pulses) and the next state after load (or IDLE) SHALL be DONE.
REQ-026 DONE SHALL last 1 cycle with done_o=1, then return to IDLE; start_i in DONE SHALL be ignored.
REQ-027 In IDLE and DONE, pe_mux_o SHALL be PASSTHROUGH, add_zero_o all 1, and w_req_o, a_valid_o, out_valid_o all 0.
REQ-028 In the LOAD states, a_valid_o, out_valid_o SHALL be 0 and add_zero_o all 1.
REQ-029 The counter SHALL be wide enough for K+2N-2 at maximum K with no wrap-around.
REQ-030 start_i asserted while busy_o=1 SHALL be ignored, not queued.
REQ-031 With load_w_i=0, the block SHALL leave the PE stationary registers untouched (no LOAD cycle).

Reset
REQ-032 When rst_i=1 at a clock edge, the block SHALL go to IDLE, clear counters and captured K/load_w, and drive the IDLE outputs of REQ-027 with busy_o=0, done_o=0.
REQ-033 Reset mid-job (any state) SHALL abort with no done_o pulse; the first cycle after reset deassertion SHALL accept start_i.

Verification
REQ-034 N=4, start at cyc0, load_w=1, K=3 -> LOAD_SHIFT cyc1-3 (w_row 3,2,1), LOAD_LATCH cyc4 (w_row 0), COMPUTE cyc5-14, done_o=1 only at cyc15, busy_o=0 at cyc16.
REQ-035 Same job -> a_valid_o[2] high cyc7-9; out_valid_o[0] high cyc9-11; out_valid_o[3] high cyc12-14.
REQ-036 N=4, load_w=0, K=1 -> no w_req_o; COMPUTE 8 cycles cyc1-8; done_o at cyc9.
REQ-037 N=4, load_w=1, K=0 -> 4 load cycles, no a_valid_o/out_valid_o pulses, done_o at cyc5.
REQ-038 Assert rst_i at cyc8 of the REQ-034 job -> IDLE outputs at cyc9, no done_o; a new start at cyc9 is accepted.
REQ-039 start_i held high for the whole REQ-034 job -> one job only; a second job starts from IDLE at cyc16.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N weight-stationary systolic array: optional weight load
// (shift + latch), skewed activation feed / result capture, then a one-cycle done pulse.
module systolic_ctrl #(
  parameter int N  = 4,
  parameter int KW = 8,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          load_w_i,
  input  logic [KW-1:0] k_len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    pe_mux_o,
  output logic [N-1:0]  add_zero_o,
  output logic          w_req_o,
  output logic [RW-1:0] w_row_o,
  output logic [N-1:0]  a_valid_o,
  output logic [N-1:0]  out_valid_o
);

  // PE mux encoding: 0 = PASSTHROUGH, 1 = LOAD, 2 = PROCESS
  localparam logic [1:0] MUX_PASS = 2'd0;
  localparam logic [1:0] MUX_LOAD = 2'd1;
  localparam logic [1:0] MUX_PROC = 2'd2;

  // Extra bits cover the 2N-2 skew on top of the largest K.
  localparam int CW = KW + $clog2(2 * N) + 1;
  localparam logic [CW-1:0] LAST_SHIFT = CW'((N > 1) ? (N - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_SHIFT, S_LOAD_LATCH, S_COMPUTE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic          load_w_q, load_w_d;
  logic [CW-1:0] k_ext;
  logic [CW-1:0] t_last;
  logic          compute_active;

  assign k_ext  = CW'(k_q);
  assign t_last = k_ext + CW'(2 * N - 2);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      load_w_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      load_w_q <= load_w_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    load_w_d = load_w_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          k_d      = k_len_i;
          load_w_d = load_w_i;
          cnt_d    = '0;
          if (load_w_i && (N > 1))  state_d = S_LOAD_SHIFT;
          else if (load_w_i)        state_d = S_LOAD_LATCH;
          else if (k_len_i == '0)   state_d = S_DONE;
          else                      state_d = S_COMPUTE;
        end
      end
      S_LOAD_SHIFT: begin
        if (cnt_q == LAST_SHIFT) begin
          cnt_d   = '0;
          state_d = S_LOAD_LATCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD_LATCH: begin
        cnt_d   = '0;
        state_d = (k_q == '0) ? S_DONE : S_COMPUTE;
      end
      S_COMPUTE: begin
        if (cnt_q == t_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_o         = (state_q != S_IDLE);
    done_o         = (state_q == S_DONE);
    pe_mux_o       = MUX_PASS;
    w_req_o        = 1'b0;
    w_row_o        = '0;
    compute_active = 1'b0;
    case (state_q)
      S_LOAD_SHIFT: begin
        // Deepest row goes first so it has shifted furthest when the latch fires.
        w_req_o = load_w_q;
        w_row_o = RW'(N - 1) - cnt_q[RW-1:0];
      end
      S_LOAD_LATCH: begin
        pe_mux_o = load_w_q ? MUX_LOAD : MUX_PASS;
        w_req_o  = load_w_q;
      end
      S_COMPUTE: begin
        pe_mux_o       = MUX_PROC;
        compute_active = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    if (gi == 0) begin : g_top
      assign add_zero_o[gi] = 1'b1;
    end else begin : g_inner
      assign add_zero_o[gi] = !compute_active;
    end
    assign a_valid_o[gi] = compute_active &&
                           (cnt_q >= CW'(gi)) && (cnt_q < CW'(gi) + k_ext);
    assign out_valid_o[gi] = compute_active &&
                             (cnt_q >= CW'(N + gi)) && (cnt_q < CW'(N + gi) + k_ext);
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl (N=4): every busy cycle must match the next queued record.
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int KW = 8;
  localparam logic [1:0] MUX_PASS = 2'd0;
  localparam logic [1:0] MUX_LOAD = 2'd1;
  localparam logic [1:0] MUX_PROC = 2'd2;
  localparam int NEVER = 1000000;

  logic          clk;
  logic          rst;
  logic          start;
  logic          load_w;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic [1:0]    pe_mux;
  logic [N-1:0]  add_zero;
  logic          w_req;
  logic [1:0]    w_row;
  logic [N-1:0]  a_valid;
  logic [N-1:0]  out_valid;

  systolic_ctrl #(.N(N), .KW(KW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .load_w_i   (load_w),
    .k_len_i    (k_len),
    .busy_o     (busy),
    .done_o     (done),
    .pe_mux_o   (pe_mux),
    .add_zero_o (add_zero),
    .w_req_o    (w_req),
    .w_row_o    (w_row),
    .a_valid_o  (a_valid),
    .out_valid_o(out_valid)
  );

  typedef struct {
    int         cyc;
    logic [1:0] mux;
    logic       w_req;
    logic [1:0] w_row;
    logic [3:0] a;
    logic [3:0] o;
    logic [3:0] az;
    logic       done;
  } rec_t;

  rec_t exp_q[$];
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   last_done;
  bit   mon_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic add_rec(input int c, input int abort_cyc, input logic [1:0] mux, input logic wr,
                         input logic [1:0] row, input logic [3:0] a, input logic [3:0] o,
                         input logic [3:0] az, input logic dn);
    rec_t r;
    if (c > abort_cyc) return;
    r.cyc = c; r.mux = mux; r.w_req = wr; r.w_row = row;
    r.a = a; r.o = o; r.az = az; r.done = dn;
    exp_q.push_back(r);
  endtask

  // Expected busy-cycle trace of a job whose start is sampled at the end of cycle s.
  task automatic push_job(input int s, input bit lw, input int k, input int abort_cyc);
    int c;
    logic [3:0] a;
    logic [3:0] o;
    c = s + 1;
    if (lw) begin
      for (int i = 0; i < N - 1; i++) begin
        add_rec(c, abort_cyc, MUX_PASS, 1'b1, 2'(N - 1 - i), 4'b0, 4'b0, 4'b1111, 1'b0);
        c++;
      end
      add_rec(c, abort_cyc, MUX_LOAD, 1'b1, 2'd0, 4'b0, 4'b0, 4'b1111, 1'b0);
      c++;
    end
    if (k > 0) begin
      for (int t = 0; t <= k + 2 * N - 2; t++) begin
        for (int r = 0; r < N; r++) begin
          a[r] = (t >= r) && (t <= r + k - 1);
          o[r] = (t >= N + r) && (t <= N + r + k - 1);
        end
        add_rec(c, abort_cyc, MUX_PROC, 1'b0, 2'd0, a, o, 4'b0001, 1'b0);
        c++;
      end
    end
    add_rec(c, abort_cyc, MUX_PASS, 1'b0, 2'd0, 4'b0, 4'b0, 4'b1111, 1'b1);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_done(input string name, input int expected);
    n_tests++;
    if (last_done !== expected) begin
      n_fail++;
      $display("FAIL %s: done_o seen at cycle %0d, required cycle %0d", name, last_done, expected);
    end else begin
      $display("[TB] %s: done_o at cycle %0d ok", name, last_done);
    end
  endtask

  // Monitor: busy cycles pop a record; idle cycles must show the idle output set.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (done) last_done = cyc;
        n_tests++;
        if (busy) begin
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_busy: cycle %0d busy=1 mux=%0d a=%b o=%b done=%b, required idle",
                     cyc, pe_mux, a_valid, out_valid, done);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || pe_mux !== e.mux || w_req !== e.w_req ||
                (e.w_req && w_row !== e.w_row) || a_valid !== e.a || out_valid !== e.o ||
                add_zero !== e.az || done !== e.done) begin
              n_fail++;
              $display("FAIL busy_cycle: got cyc=%0d mux=%0d wreq=%b row=%0d a=%b o=%b az=%b done=%b; required cyc=%0d mux=%0d wreq=%b row=%0d a=%b o=%b az=%b done=%b",
                       cyc, pe_mux, w_req, w_row, a_valid, out_valid, add_zero, done,
                       e.cyc, e.mux, e.w_req, e.w_row, e.a, e.o, e.az, e.done);
            end
          end
        end else begin
          if (done !== 1'b0 || pe_mux !== MUX_PASS || add_zero !== 4'b1111 ||
              w_req !== 1'b0 || a_valid !== 4'b0 || out_valid !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_outputs: cycle %0d got done=%b mux=%0d az=%b wreq=%b a=%b o=%b, required 0/0/1111/0/0000/0000",
                     cyc, done, pe_mux, add_zero, w_req, a_valid, out_valid);
          end
        end
      end
    end
  end

  initial begin
    int s;
    n_tests   = 0;
    n_fail    = 0;
    last_done = -1;
    mon_en    = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    load_w    = 1'b0;
    k_len     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    goto(cyc + 2);

    // Load + K=3: load cycles 1-4, compute 5-14, done at 15.
    s = cyc; last_done = -1;
    start = 1'b1; load_w = 1'b1; k_len = 8'd3;
    push_job(s, 1'b1, 3, NEVER);
    goto(s + 1); start = 1'b0; load_w = 1'b0; k_len = 8'd9;
    goto(s + 20);
    check_done("load_k3", s + 15);
    $display("[TB] job load_k3 started at cycle %0d", s);

    // Reuse weights, K=1: compute 1-8, done at 9.
    s = cyc; last_done = -1;
    start = 1'b1; load_w = 1'b0; k_len = 8'd1;
    push_job(s, 1'b0, 1, NEVER);
    goto(s + 1); start = 1'b0;
    goto(s + 14);
    check_done("reuse_k1", s + 9);

    // Load with K=0: load 1-4, no compute, done at 5.
    s = cyc; last_done = -1;
    start = 1'b1; load_w = 1'b1; k_len = 8'd0;
    push_job(s, 1'b1, 0, NEVER);
    goto(s + 1); start = 1'b0;
    goto(s + 10);
    check_done("load_k0", s + 5);

    // Reset during compute at cycle 8; new reuse K=1 job accepted at cycle 9.
    s = cyc; last_done = -1;
    start = 1'b1; load_w = 1'b1; k_len = 8'd3;
    push_job(s, 1'b1, 3, s + 8);
    goto(s + 1); start = 1'b0;
    goto(s + 8); rst = 1'b1;
    goto(s + 9); rst = 1'b0; start = 1'b1; load_w = 1'b0; k_len = 8'd1;
    push_job(s + 9, 1'b0, 1, NEVER);
    goto(s + 10); start = 1'b0;
    goto(s + 24);
    check_done("reset_then_restart", s + 18);

    // start held through the job: second job starts from IDLE at cycle 16.
    s = cyc; last_done = -1;
    start = 1'b1; load_w = 1'b1; k_len = 8'd3;
    push_job(s, 1'b1, 3, NEVER);
    push_job(s + 16, 1'b1, 3, NEVER);
    goto(s + 17); start = 1'b0;
    goto(s + 36);
    check_done("start_held", s + 31);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_records: %0d expected busy cycles never seen, required 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
